// File: rtl/digit_scan_ctrl.sv
// Scan controller for a binary-to-one-hot digit decoder: steps sel through 2**N
// positions with a DIV-cycle enabled dwell and BLANK cycles of blanking between positions.
module digit_scan_ctrl #(
  parameter int N     = 2,
  parameter int W     = 4,
  parameter int DIV   = 4,
  parameter int BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic [W*(2**N)-1:0]   digits,
  output logic [N-1:0]          sel,
  output logic                  en,
  output logic [W-1:0]          dout,
  output logic                  wrap
);

  localparam int MAXC = (DIV > BLANK) ? DIV : BLANK;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [N-1:0]  SEL_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_BLK  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   sel_q, sel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           en_q, en_d;
  logic           wrap_q, wrap_d;
  logic [W-1:0]   dout_q, dout_d;

  // Next-state logic; en/wrap/dout are computed for the state being entered so they register cleanly.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    en_d    = 1'b0;
    wrap_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run) begin
          state_d = S_ON;
          en_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ON: begin
        if (!run) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DIV_LAST) begin
          sel_d  = sel_q + N'(1);
          cnt_d  = '0;
          wrap_d = (sel_q == SEL_LAST);
          // The select advances on the same edge that enables blanking, never while enabled.
          if (BLANK > 0) begin
            state_d = S_BLK;
          end else begin
            en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          en_d  = 1'b1;
        end
      end
      S_BLK: begin
        if (!run) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == BLK_LAST) begin
          state_d = S_ON;
          cnt_d   = '0;
          en_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        sel_d   = '0;
        cnt_d   = '0;
      end
    endcase
    dout_d = digits[W*sel_d +: W];
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
      dout_q  <= dout_d;
    end
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign dout = dout_q;
  assign wrap = wrap_q;

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed scan controller that drives a parameterised binary-to-one-hot decoder directly upstream. It steps a select code through all 2**N positions at a programmable dwell rate. It inserts a blanking interval between positions, holding the decoder enable low so no two outputs are ever active across a select change. It also presents the data word belonging to the current position, aligned with the select code.

## Interface

Parameters:
- N, 2, select width; the block scans 2**N positions.
- W, 4, data width per position.
- DIV, 4, clock cycles per position with enable high; legal range ≥1.
- BLANK, 1, clock cycles of enable-low blanking after each position; legal range ≥0, where 0 disables blanking.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  1 = scan; 0 = stop with enable low and select held.
- digits  input  W*2**N  packed data; position k occupies bits [W*k+W-1 : W*k].
- sel  output  N  select code; connects to decoder input x.
- en  output  1  decoder enable; connects to decoder en.
- dout  output  W  data slice for the position currently on sel.
- wrap  output  1  one-cycle pulse when sel returns from 2**N-1 to 0.

## Operation

- All outputs are registered. Reset values: state IDLE, sel=0, en=0, dout=0, wrap=0, dwell counter=0.
- The state machine has three states: IDLE, ON and BLK.
  - IDLE: en=0, counter cleared. If run=1, go to ON on the next edge and keep sel unchanged (scanning resumes at the held position).
  - ON: en=1. The counter counts 0..DIV-1. On the edge where the count reaches DIV-1, sel increments modulo 2**N and the counter clears.
    - With BLANK>0, that edge also moves to BLK and drops en.
    - With BLANK=0, the state stays ON with en=1.
  - BLK: en=0. The counter counts 0..BLANK-1. On the edge where the count reaches BLANK-1, go to ON with en=1 and clear the counter.
- Select changes only occur on the same edge where en falls (BLANK>0). The decoder therefore never sees a new code while enabled.
- run=0 in ON or BLK moves to IDLE on the next edge. That edge sets en=0, holds sel and clears the counter. A partial dwell is discarded.
- run=1 in IDLE gives a full DIV-cycle dwell on resume.
- dout is registered every cycle as the slice of digits selected by the next-state value of sel. dout therefore always matches sel, and a change on digits appears on dout one edge later.
- wrap is registered and high for exactly one cycle after the edge on which sel goes from 2**N-1 to 0. It is never asserted from IDLE.
- The counter width is wide enough for max(DIV, BLANK)-1. sel increments with natural N-bit wrap.
- Reset asserted mid-scan forces all reset values immediately, independent of clk. After release, the first edge with run=1 enters ON at sel=0.

## Timing

- Reset release with run=1: the first edge gives en=1, sel=0. en remains high for DIV cycles.
- Per-position period is DIV+BLANK cycles; a frame is (DIV+BLANK)*2**N cycles.
- Example with DIV=4, BLANK=1, N=2:
  - en=1 on cycles 1–4, en=0 with sel=1 on cycle 5, en=1 on cycles 6–9.
  - wrap pulses on cycle 20, together with sel=0 and en=0.
- run falling is seen at the next edge (1-cycle latency to en=0). run rising gives en=1 one edge after being sampled.
- digits→dout latency is 1 cycle. sel and dout always change on the same edge.

## Test plan

- Reset, then run=1, N=2, DIV=4, BLANK=1 → sel sequence 0,1,2,3,0 with exactly 4 cycles en=1 and 1 cycle en=0 per position; wrap high for 1 cycle every 20 cycles.
- Across every edge where sel changes, check en → en is 0 after the edge (BLANK>0). Repeat with BLANK=0 → en stays 1 continuously and sel steps every 4 cycles.
- digits=16'hA3C5 → dout reads 5, C, 3, A for sel 0..3. Change digits to 16'h0000 mid-dwell → dout=0 one cycle later.
- run=0 during the 2nd ON cycle at sel=2 → en=0 next edge, sel held at 2. Restore run=1 → en=1 at sel=2 for a full 4 cycles.
- Assert rst asynchronously mid-BLK at sel=3 → sel=0, en=0, dout=0, wrap=0 before the next clk edge. After release, the scan restarts at sel=0.
- N=3, DIV=1, BLANK=2 → 8 positions, period 3 cycles, wrap every 24 cycles.
